// File: rtl/riscv_pkg.sv
// Shared types and constants for the pipeline slice.
// Holds the pipe register state encoding and the occupancy width.
package riscv_pkg;

    localparam int PIPE_LEVEL_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

    function automatic logic [PIPE_LEVEL_W-1:0] state_level(
        input pipe_state_t s
    );
        logic [PIPE_LEVEL_W-1:0] l;
        l = '0;
        unique case (s)
            FULL:    l = 2'd1;
            SKID:    l = 2'd2;
            default: l = 2'd0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/syn_reg.sv
// Write-enabled storage register with asynchronous reset to INITIAL.
// Used as the data holder for pipe_reg main and skid entries.
module syn_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] INITIAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // capture d only on strobe; otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= INITIAL;
        end else if (wr_en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_reg.sv
// One-cycle valid/ready pipeline register with optional skid buffer.
// Define PIPE_REG_SKID_EN for the registered-ready skid variant.
import riscv_pkg::*;

module pipe_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] INITIAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [PIPE_LEVEL_W-1:0] level
);

    pipe_state_t      state_q;
    pipe_state_t      state_d;
    logic             in_fire;
    logic             out_fire;
    logic             main_we;
    logic [WIDTH-1:0] main_d;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_valid = (state_q != EMPTY);
    assign level     = state_level(state_q);

`ifdef PIPE_REG_SKID_EN
    logic             skid_we;
    logic [WIDTH-1:0] skid_q;
    logic             rdy_q;

    // refilling main from skid when draining the second entry
    assign main_d   = (state_q == SKID) ? skid_q : in_data;
    assign in_ready = rdy_q;

    syn_reg #(
        .WIDTH   (WIDTH),
        .INITIAL (INITIAL)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .wr_en (skid_we),
        .d     (in_data),
        .q     (skid_q)
    );

    // ready registered from next state so out_ready never reaches it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q <= 1'b1;
        end else begin
            rdy_q <= (state_d != SKID);
        end
    end
`else
    assign main_d   = in_data;
    assign in_ready = ~out_valid | out_ready;
`endif

    syn_reg #(
        .WIDTH   (WIDTH),
        .INITIAL (INITIAL)
    ) u_main (
        .clk   (clk),
        .rst   (rst),
        .wr_en (main_we),
        .d     (main_d),
        .q     (out_data)
    );

    // control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and capture strobes; flush overrides any capture
    always_comb begin
        state_d = state_q;
        main_we = 1'b0;
`ifdef PIPE_REG_SKID_EN
        skid_we = 1'b0;
`endif
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = FULL;
                    main_we = 1'b1;
                end
            end
            FULL: begin
`ifdef PIPE_REG_SKID_EN
                if (in_fire && out_fire) begin
                    main_we = 1'b1;
                end else if (in_fire) begin
                    state_d = SKID;
                    skid_we = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
`else
                if (in_fire) begin
                    main_we = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
`endif
            end
`ifdef PIPE_REG_SKID_EN
            SKID: begin
                if (out_fire) begin
                    state_d = FULL;
                    main_we = 1'b1;
                end
            end
`endif
            default: begin
                state_d = EMPTY;
            end
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_we = 1'b0;
`ifdef PIPE_REG_SKID_EN
            skid_we = 1'b0;
`endif
        end
    end

endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data path width in bits.
REQ-002 SHALL have parameter INITIAL, default 0, reset value of all data storage.
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-006 SHALL have port in_valid  input  1  upstream entry offered.
REQ-007 SHALL have port in_ready  output  1  stage accepts an entry this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream entry payload.
REQ-009 SHALL have port out_valid  output  1  output entry held.
REQ-010 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-011 SHALL have port out_data  output  WIDTH  output entry payload.
REQ-012 SHALL have port level  output  2  entries held (0..2).

Function
REQ-013 Transfer SHALL occur only on a cycle with valid and ready both high: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-014 Entries SHALL leave in arrival order, none lost or duplicated absent flush.
REQ-015 Latency SHALL be 1 cycle: entry accepted at edge N is on out_data/out_valid after edge N.
REQ-016 With skid: states EMPTY (level 0), FULL (level 1, main held), SKID (level 2, main + skid held).
REQ-017 EMPTY: in_fire -> FULL, main <= in_data; else stay.
REQ-018 FULL: in_fire & out_fire -> FULL, main <= in_data; in_fire & !out_fire -> SKID, skid <= in_data; out_fire only -> EMPTY.
REQ-019 SKID: in_ready SHALL be 0; out_fire -> FULL, main <= skid; else stay.
REQ-020 in_ready SHALL equal (state != SKID), driven from a flop, no combinational path from out_ready.
REQ-021 out_valid SHALL equal (state != EMPTY); out_data SHALL always equal main storage.
REQ-022 Data storage SHALL be written only on capture; held value SHALL persist when not written, including after drain.
REQ-023 flush SHALL force EMPTY at next edge, dropping any coincident in_fire; out_fire in that cycle still counts; data storage unchanged.
REQ-024 in_valid high while in_ready low SHALL have no effect; upstream holds in_data stable.

Reset
REQ-025 rst high SHALL immediately force state EMPTY, out_valid 0, level 0, in_ready 1, main and skid storage INITIAL.
REQ-026 rst mid-operation SHALL discard all held entries; first edge after rst release behaves as EMPTY.
REQ-027 rst SHALL take priority over flush and all handshakes.

Configuration
REQ-028 Macro PIPE_REG_SKID_EN SHALL select the skid buffer.
REQ-029 Defined: behaviour per REQ-016..REQ-020, full throughput with registered in_ready.
REQ-030 Undefined: no skid storage, states EMPTY/FULL only, level max 1, in_ready = !out_valid | out_ready (combinational); FULL with in_fire & out_fire stays FULL with new data.

Structure
REQ-031 Shared package riscv_pkg SHALL hold state enum pipe_state_t (EMPTY, FULL, SKID) and level width constant PIPE_LEVEL_W = 2.
REQ-032 Main and skid storage SHALL each be one instance of existing syn_reg (WIDTH, INITIAL) with wr_en as capture strobe; control FSM in pipe_reg.

Verification
REQ-033 Reset then in_valid=1, in_data=0x11, out_ready=1 -> out_data=0x11, out_valid=1 one cycle later; level=1.
REQ-034 Continuous stream 0x1..0x8, out_ready=1 -> one output per cycle, in order, in_ready never 0.
REQ-035 SKID_EN: FULL with 0xA, out_ready=0, offer 0xB -> level=2, in_ready=0; out_ready=1 -> 0xA then 0xB on consecutive cycles.
REQ-036 level=2, flush=1 with in_valid=1, in_data=0xC -> next cycle out_valid=0, level=0, 0xC never output.
REQ-037 rst asserted mid-stream at level=2 -> out_valid=0, in_ready=1, out_data=INITIAL asynchronously, before next edge.
REQ-038 SKID_EN undefined: FULL, out_ready=0 -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle.
